// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encodings,
// major opcode values and immediate-format selects.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_R,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_IALU   = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_LUI    = 7'd55;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd5;

endpackage

// File: rtl/uc_multicycle_if.sv
// Bus bundle between the control unit (master) and its memory/datapath
// environment (slave): fetch/data handshakes, control strobes and status.
interface uc_multicycle_if #(
    parameter int INSTRET_W = 16
);
    logic [6:0]           opcode;
    logic                 imem_req;
    logic                 imem_ack;
    logic                 dmem_req;
    logic                 dmem_ack;
    logic [2:0]           ImmSel;
    logic                 branch;
    logic                 jump;
    logic                 jumplink;
    logic                 memtoreg;
    logic                 MemW;
    logic                 ALUsrc;
    logic                 RegW;
    logic                 LUItoReg;
    logic                 IRW;
    logic                 PCW;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;
    logic                 trap;

    modport master (
        input  opcode, imem_ack, dmem_ack,
        output imem_req, dmem_req, ImmSel, branch, jump, jumplink, memtoreg,
               MemW, ALUsrc, RegW, LUItoReg, IRW, PCW, state, instret, trap
    );

    modport slave (
        output opcode, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ImmSel, branch, jump, jumplink, memtoreg,
               MemW, ALUsrc, RegW, LUItoReg, IRW, PCW, state, instret, trap
    );

endinterface

// File: rtl/uc_decode.sv
// Combinational opcode decoder: latched opcode -> instruction class,
// immediate format select and ALU operand-B select.
module uc_decode
    import uc_pkg::*;
(
    input  logic [6:0] i_ir_op,
    output iclass_t    o_class,
    output logic [2:0] o_immsel,
    output logic       o_alusrc
);

    always_comb begin
        o_class  = CL_ILLEGAL;
        o_immsel = IMM_NONE;
        o_alusrc = 1'b0;
        unique case (i_ir_op)
            OP_R:      begin o_class = CL_R;      o_immsel = IMM_NONE; end
            OP_IALU:   begin o_class = CL_IALU;   o_immsel = IMM_I; o_alusrc = 1'b1; end
            OP_LOAD:   begin o_class = CL_LOAD;   o_immsel = IMM_I; o_alusrc = 1'b1; end
            OP_STORE:  begin o_class = CL_STORE;  o_immsel = IMM_S; o_alusrc = 1'b1; end
            OP_BRANCH: begin o_class = CL_BRANCH; o_immsel = IMM_B; end
            OP_JAL:    begin o_class = CL_JAL;    o_immsel = IMM_J; end
            OP_JALR:   begin o_class = CL_JALR;   o_immsel = IMM_I; o_alusrc = 1'b1; end
            OP_LUI:    begin o_class = CL_LUI;    o_immsel = IMM_U; end
            default:   begin o_class = CL_ILLEGAL; o_immsel = IMM_NONE; end
        endcase
    end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, ack wait
// counter and retired-instruction counter. Define UC_TRAP_EN for trap support.
//
// state  | meaning
// FETCH  | imem_req high, latch opcode on imem_ack
// DECODE | one cycle, classify latched opcode
// EXEC   | branch/jump strobes; branch (and NOP) retire here
// MEM    | dmem_req high until dmem_ack; store retires on ack
// WB     | register write-back, retire
// TRAP   | illegal opcode or ack timeout; left only by rst
module uc_multicycle
    import uc_pkg::*;
#(
    parameter int WAIT_MAX  = 15,
    parameter int INSTRET_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    uc_multicycle_if.master        bus
);

`ifdef UC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [6:0]           r_ir_op;
    logic [7:0]           r_wait;
    logic [INSTRET_W-1:0] r_instret;

    iclass_t              w_class;
    logic [2:0]           w_dec_immsel;
    logic                 w_dec_alusrc;
    logic                 w_wait_max;

    logic                 w_imem_req;
    logic                 w_dmem_req;
    logic [2:0]           w_immsel;
    logic                 w_branch;
    logic                 w_jump;
    logic                 w_jumplink;
    logic                 w_memtoreg;
    logic                 w_memw;
    logic                 w_alusrc;
    logic                 w_regw;
    logic                 w_luitoreg;
    logic                 w_irw;
    logic                 w_pcw;

    uc_decode u_decode (
        .i_ir_op  (r_ir_op),
        .o_class  (w_class),
        .o_immsel (w_dec_immsel),
        .o_alusrc (w_dec_alusrc)
    );

    assign w_wait_max = (r_wait == 8'(WAIT_MAX));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_nxt;
    end

    // A missing ack only times out when the count has already reached WAIT_MAX,
    // so an ack in that same cycle is still taken.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FETCH: begin
                if (bus.imem_ack)                 w_state_nxt = ST_DECODE;
                else if (TRAP_EN && w_wait_max)   w_state_nxt = ST_TRAP;
            end
            ST_DECODE: begin
                if (TRAP_EN && (w_class == CL_ILLEGAL)) w_state_nxt = ST_TRAP;
                else                                    w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (w_class)
                    CL_LOAD, CL_STORE:     w_state_nxt = ST_MEM;
                    CL_BRANCH, CL_ILLEGAL: w_state_nxt = ST_FETCH;
                    default:               w_state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack)
                    w_state_nxt = (w_class == CL_LOAD) ? ST_WB : ST_FETCH;
                else if (TRAP_EN && w_wait_max)
                    w_state_nxt = ST_TRAP;
            end
            ST_WB:   w_state_nxt = ST_FETCH;
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_immsel   = 3'd0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_jumplink = 1'b0;
        w_memtoreg = 1'b0;
        w_memw     = 1'b0;
        w_alusrc   = 1'b0;
        w_regw     = 1'b0;
        w_luitoreg = 1'b0;
        w_irw      = 1'b0;
        w_pcw      = 1'b0;
        if (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            w_immsel = w_dec_immsel;
            w_alusrc = w_dec_alusrc;
        end
        unique case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                w_irw      = bus.imem_ack;
            end
            ST_EXEC: begin
                w_branch = (w_class == CL_BRANCH);
                w_jump   = (w_class == CL_JAL) || (w_class == CL_JALR);
                w_pcw    = (w_class == CL_BRANCH) || (w_class == CL_ILLEGAL);
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_memw     = (w_class == CL_STORE);
                w_pcw      = (w_class == CL_STORE) && bus.dmem_ack;
            end
            ST_WB: begin
                w_regw     = 1'b1;
                w_memtoreg = (w_class == CL_LOAD);
                w_jumplink = (w_class == CL_JAL) || (w_class == CL_JALR);
                w_luitoreg = (w_class == CL_LUI);
                w_pcw      = 1'b1;
            end
            default: ;
        endcase
    end

    // Wait count restarts on every state change; it saturates so unbounded
    // waits in the trap-less build never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_op   <= 7'd0;
            r_wait    <= 8'd0;
            r_instret <= '0;
        end else begin
            if (w_irw) r_ir_op <= bus.opcode;
            if ((r_state == ST_FETCH || r_state == ST_MEM) && (w_state_nxt == r_state)) begin
                if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_pcw) r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    assign bus.imem_req = w_imem_req;
    assign bus.dmem_req = w_dmem_req;
    assign bus.ImmSel   = w_immsel;
    assign bus.branch   = w_branch;
    assign bus.jump     = w_jump;
    assign bus.jumplink = w_jumplink;
    assign bus.memtoreg = w_memtoreg;
    assign bus.MemW     = w_memw;
    assign bus.ALUsrc   = w_alusrc;
    assign bus.RegW     = w_regw;
    assign bus.LUItoReg = w_luitoreg;
    assign bus.IRW      = w_irw;
    assign bus.PCW      = w_pcw;
    assign bus.state    = r_state;
    assign bus.instret  = r_instret;
`ifdef UC_TRAP_EN
    assign bus.trap     = (r_state == ST_TRAP);
`else
    assign bus.trap     = 1'b0;
`endif

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed self-checking bench for uc_multicycle; retire events are checked
// against a scoreboard filled as each instruction is issued.
module tb_uc_multicycle;

    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uc_multicycle_if #(.INSTRET_W(IW)) bus ();

    uc_multicycle #(.WAIT_MAX(15), .INSTRET_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [IW-1:0] ib;
    } exp_t;

    exp_t          sb_q[$];
    logic [IW-1:0] m_instret = '0;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, want);
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    endtask

    task automatic chk4(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    endtask

    function automatic logic legal(input logic [6:0] op);
        return op inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55};
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'd19, 7'd3, 7'd103: return 3'd0;
            7'd35:               return 3'd1;
            7'd99:               return 3'd2;
            7'd55:               return 3'd3;
            7'd111:              return 3'd4;
            default:             return 3'd5;
        endcase
    endfunction

    function automatic logic exp_alusrc(input logic [6:0] op);
        return op inside {7'd19, 7'd3, 7'd35, 7'd103};
    endfunction

    task automatic check_idle();
        chk3("idle_state", bus.state, 3'd0);
        chk1("idle_imem_req", bus.imem_req, 1'b1);
        chk1("idle_ctrl_zero", |{bus.ImmSel, bus.branch, bus.jump, bus.jumplink, bus.memtoreg,
                                 bus.MemW, bus.ALUsrc, bus.RegW, bus.LUItoReg, bus.IRW,
                                 bus.PCW, bus.dmem_req}, 1'b0);
        chk4("idle_instret", bus.instret, m_instret);
        chk1("idle_trap", bus.trap, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.opcode   = 7'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_instret = '0;
        sb_q.delete();
        #1;
        check_idle();
    endtask

    // Starts in the current FETCH cycle (just after a negedge) and ends in the
    // first FETCH cycle of the following instruction.
    task automatic exec_instr(input logic [6:0] op, input int fwait, input int dwait);
        logic       is_st, is_ld, is_br, is_ill, is_j, has_wb;
        logic [2:0] ret_st;
        is_st  = (op == 7'd35);
        is_ld  = (op == 7'd3);
        is_br  = (op == 7'd99);
        is_ill = !legal(op);
        is_j   = (op == 7'd111) || (op == 7'd103);
        has_wb = !(is_st || is_br || is_ill);
        ret_st = is_st ? 3'd3 : ((is_br || is_ill) ? 3'd2 : 3'd4);
        sb_q.push_back('{st: ret_st, ib: m_instret});
        m_instret = m_instret + 4'd1;

        for (int i = 0; i < fwait; i++) begin
            bus.imem_ack = 1'b0;
            #1;
            chk3("fetch_wait_state", bus.state, 3'd0);
            chk1("fetch_wait_irw", bus.IRW, 1'b0);
            @(negedge clk);
        end
        bus.opcode   = op;
        bus.imem_ack = 1'b1;
        #1;
        chk3("fetch_state", bus.state, 3'd0);
        chk1("fetch_irw", bus.IRW, 1'b1);
        chk1("fetch_imem_req", bus.imem_req, 1'b1);

        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.opcode   = 7'h7f;
        #1;
        chk3("dec_state", bus.state, 3'd1);
        chk3("dec_immsel", bus.ImmSel, exp_imm(op));
        chk1("dec_alusrc", bus.ALUsrc, exp_alusrc(op));
        chk1("dec_imem_req", bus.imem_req, 1'b0);

        @(negedge clk);
        #1;
        chk3("exec_state", bus.state, 3'd2);
        chk1("exec_branch", bus.branch, is_br);
        chk1("exec_jump", bus.jump, is_j);
        chk1("exec_pcw", bus.PCW, is_br || is_ill);
        chk1("exec_regw", bus.RegW, 1'b0);
        chk3("exec_immsel", bus.ImmSel, exp_imm(op));

        if (is_st || is_ld) begin
            for (int i = 0; i < dwait; i++) begin
                @(negedge clk);
                bus.dmem_ack = 1'b0;
                #1;
                chk3("mem_wait_state", bus.state, 3'd3);
                chk1("mem_wait_memw", bus.MemW, is_st);
                chk1("mem_wait_dmem_req", bus.dmem_req, 1'b1);
                chk1("mem_wait_pcw", bus.PCW, 1'b0);
            end
            @(negedge clk);
            bus.dmem_ack = 1'b1;
            #1;
            chk3("mem_ack_state", bus.state, 3'd3);
            chk1("mem_ack_memw", bus.MemW, is_st);
            chk1("mem_ack_pcw", bus.PCW, is_st);
            chk1("mem_ack_regw", bus.RegW, 1'b0);
            chk3("mem_ack_immsel", bus.ImmSel, exp_imm(op));
        end

        if (has_wb) begin
            @(negedge clk);
            bus.dmem_ack = 1'b0;
            #1;
            chk3("wb_state", bus.state, 3'd4);
            chk1("wb_regw", bus.RegW, 1'b1);
            chk1("wb_memtoreg", bus.memtoreg, is_ld);
            chk1("wb_jumplink", bus.jumplink, is_j);
            chk1("wb_luitoreg", bus.LUItoReg, op == 7'd55);
            chk1("wb_pcw", bus.PCW, 1'b1);
            chk3("wb_immsel", bus.ImmSel, exp_imm(op));
        end

        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        chk3("ret_state", bus.state, 3'd0);
        chk4("ret_instret", bus.instret, m_instret);
        chk1("ret_regw", bus.RegW, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && bus.PCW) begin
            if (sb_q.size() == 0) begin
                chk1("sb_unexpected_retire", bus.PCW, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk3("sb_retire_state", bus.state, e.st);
                chk4("sb_instret_pre", bus.instret, e.ib);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode   = 7'd0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        do_reset();
        exec_instr(7'd19, 0, 0);
        exec_instr(7'd35, 0, 3);
        exec_instr(7'd111, 0, 0);
        exec_instr(7'd103, 1, 0);
        exec_instr(7'd3, 2, 1);
        exec_instr(7'd99, 0, 0);
        exec_instr(7'd55, 0, 0);
        exec_instr(7'd51, 3, 0);
        exec_instr(7'd19, 15, 0);
        exec_instr(7'd35, 0, 15);
`ifndef UC_TRAP_EN
        exec_instr(7'd0, 0, 0);
        exec_instr(7'd127, 2, 0);
`endif

        do_reset();
        repeat (16) exec_instr(7'd51, 0, 0);
        chk4("instret_wrap", bus.instret, 4'd0);

        bus.opcode   = 7'd3;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk3("midmem_state", bus.state, 3'd3);
        chk1("midmem_dmem_req", bus.dmem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk3("midmem_rst_hold", bus.state, 3'd3);
        @(negedge clk);
        rst = 1'b0;
        m_instret = '0;
        #1;
        check_idle();

`ifdef UC_TRAP_EN
        for (int i = 0; i < 16; i++) begin
            bus.imem_ack = 1'b0;
            #1;
            chk3("tmo_wait_state", bus.state, 3'd0);
            @(negedge clk);
        end
        #1;
        chk3("tmo_state", bus.state, 3'd5);
        chk1("tmo_trap", bus.trap, 1'b1);
        chk1("tmo_imem_req", bus.imem_req, 1'b0);

        do_reset();
        bus.opcode   = 7'd0;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        #1;
        chk3("ill_dec_state", bus.state, 3'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk3("ill_trap_state", bus.state, 3'd5);
            chk1("ill_trap", bus.trap, 1'b1);
            chk1("ill_pcw", bus.PCW, 1'b0);
            chk1("ill_imem_req", bus.imem_req, 1'b0);
            chk4("ill_instret", bus.instret, m_instret);
        end
        do_reset();
`endif

        chk1("sb_drained", sb_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
